// File: rtl/mod_pipe_if.sv
// Streaming bus for mod_pipe: input sample (dividend, mode) and result (quotient, remainder),
// each side with its own valid/ready pair.
interface mod_pipe_if #(
    parameter int WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_dividend;
    logic [1:0]       i_mode;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_result;

    modport master (
        output i_valid, i_dividend, i_mode, i_ready,
        input  o_ready, o_valid, o_quotient, o_result
    );

    modport slave (
        input  i_valid, i_dividend, i_mode, i_ready,
        output o_ready, o_valid, o_quotient, o_result
    );
endinterface

// File: rtl/mod_pipe.sv
// Three-stage constant-divisor divide/modulo: reciprocal multiply, quotient estimate and
// remainder, then a single correction. One sample per cycle, whole pipe stalls together.
module mod_pipe #(
    parameter int                 WIDTH   = 16,
    parameter int                 RECIP_W = 34,
    parameter int                 SHIFT   = 37,
    parameter int                 D0      = 12,
    parameter int                 D1      = 24,
    parameter int                 D2      = 30,
    parameter int                 D3      = 14,
    parameter logic [RECIP_W-1:0] R0      = 34'h2AAAAAAAA,
    parameter logic [RECIP_W-1:0] R1      = 34'h155555555,
    parameter logic [RECIP_W-1:0] R2      = 34'h111111111,
    parameter logic [RECIP_W-1:0] R3      = 34'h249249249
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    mod_pipe_if.slave  bus
);
    localparam int PW = WIDTH + RECIP_W;
    localparam logic [WIDTH-1:0]   DIV [4] = '{WIDTH'(D0), WIDTH'(D1), WIDTH'(D2), WIDTH'(D3)};
    localparam logic [RECIP_W-1:0] RCP [4] = '{R0, R1, R2, R3};

    typedef struct packed {
        logic [WIDTH-1:0] q_est;
        logic [WIDTH:0]   r_est;
        logic [1:0]       mode;
    } s2_t;

    logic [3:1]       r_vld_pipe;
    logic [WIDTH-1:0] r_x1;
    logic [1:0]       r_m1;
    s2_t              r_s2;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;

    logic             w_adv;
    logic [PW-1:0]    w_p;
    s2_t              w_s2;
    logic [WIDTH:0]   w_qd;
    logic [WIDTH:0]   w_d3;
    logic [WIDTH-1:0] w_q3;
    logic [WIDTH-1:0] w_r3;

    assign w_adv       = ~r_vld_pipe[3] | bus.i_ready;
    assign bus.o_ready = w_adv;
    assign bus.o_valid = r_vld_pipe[3];
    assign bus.o_quotient = r_quot;
    assign bus.o_result   = r_rem;

    // Estimate is q or q-1, so q_est*D never exceeds x and fits WIDTH+1 bits.
    assign w_p        = PW'(r_x1) * PW'(RCP[r_m1]);
    assign w_s2.q_est = WIDTH'(w_p >> SHIFT);
    assign w_qd       = (WIDTH+1)'(w_s2.q_est) * (WIDTH+1)'(DIV[r_m1]);
    assign w_s2.r_est = {1'b0, r_x1} - w_qd;
    assign w_s2.mode  = r_m1;

    always_comb begin
        w_d3 = {1'b0, DIV[r_s2.mode]};
        w_q3 = r_s2.q_est;
        w_r3 = WIDTH'(r_s2.r_est);
        if (r_s2.r_est >= w_d3) begin
            w_q3 = r_s2.q_est + 1'b1;
            w_r3 = WIDTH'(r_s2.r_est - w_d3);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_pipe <= '0;
            r_x1       <= '0;
            r_m1       <= '0;
            r_s2       <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
        end else if (w_adv) begin
            r_vld_pipe <= {r_vld_pipe[2:1], bus.i_valid};
            r_x1       <= bus.i_dividend;
            r_m1       <= bus.i_mode;
            r_s2       <= w_s2;
            // Outputs keep the last result across bubbles.
            if (r_vld_pipe[2]) begin
                r_quot <= w_q3;
                r_rem  <= w_r3;
            end
        end
    end
endmodule

// File: tb/tb_mod_pipe.sv
// Randomized and directed bench for mod_pipe against a queue-based divide/modulo model.
module tb_mod_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod_pipe_if #(.WIDTH(16)) bus ();

    mod_pipe u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        int q;
        int r;
        int c;
    } exp_t;

    exp_t        sb[$];
    int          DV[4] = '{12, 24, 30, 14};
    int          total = 0;
    int          bad = 0;
    int          advcnt = 0;
    int          acc = 0;
    logic        prev_stall = 1'b0;
    logic        last_ov = 1'b0;
    logic [31:0] prev_out = '0;
    logic [31:0] last_out = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, then judge the handshake the next rising edge will see.
    task automatic step(input logic v, input int x, input int m, input logic rdy,
                        input logic ovr, input int eq, input int er);
        logic [31:0] out;
        logic        adv;
        exp_t        e;
        @(negedge clk);
        bus.i_valid    = v;
        bus.i_dividend = 16'(x);
        bus.i_mode     = 2'(m);
        bus.i_ready    = rdy;
        #1;
        out = {bus.o_quotient, bus.o_result};
        adv = !bus.o_valid || rdy;
        chk("ordy", 32'(bus.o_ready), 32'(adv));
        if (prev_stall) chk("hold", out, prev_out);
        if (!bus.o_valid) chk("idle", out, last_out);
        else last_out = out;
        if (bus.o_valid && rdy) begin
            if (sb.size() == 0) chk("spur", 1, 0);
            else begin
                e = sb.pop_front();
                chk("quot", 32'(bus.o_quotient), e.q);
                chk("rem", 32'(bus.o_result), e.r);
                chk("lat", advcnt - e.c, 3);
            end
        end
        if (v && adv) begin
            acc++;
            if (ovr) sb.push_back('{eq, er, advcnt});
            else     sb.push_back('{x / DV[m], x % DV[m], advcnt});
        end
        prev_stall = bus.o_valid && !rdy;
        prev_out   = out;
        last_ov    = bus.o_valid;
        if (adv) advcnt++;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
        chk("drain", sb.size(), 0);
    endtask

    logic pat[12] = '{1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    logic ov[12];

    initial begin
        bus.i_valid = 1'b0; bus.i_dividend = '0; bus.i_mode = '0; bus.i_ready = 1'b1;
        #12;
        chk("rst_ov", 32'(bus.o_valid), 0);
        chk("rst_out", {bus.o_quotient, bus.o_result}, 0);
        chk("rst_ordy", 32'(bus.o_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Wide sweep per mode with i_ready held high
        for (int m = 0; m < 4; m++) begin
            for (int x = 0; x < 65536; x += 13) step(1'b1, x, m, 1'b1, 1'b0, 0, 0);
            for (int x = 65520; x < 65536; x++) step(1'b1, x, m, 1'b1, 1'b0, 0, 0);
        end
        drain();

        // Corners with literal expectations
        step(1'b1, 65535, 1, 1'b1, 1'b1, 2730, 15);
        step(1'b1, 65535, 2, 1'b1, 1'b1, 2184, 15);
        step(1'b1, 65535, 0, 1'b1, 1'b1, 5461, 3);
        step(1'b1, 100,   1, 1'b1, 1'b1, 4, 4);
        step(1'b1, 13,    3, 1'b1, 1'b1, 0, 13);
        step(1'b1, 0,     0, 1'b1, 1'b1, 0, 0);
        // Mode interleave
        step(1'b1, 47, 0, 1'b1, 1'b1, 3, 11);
        step(1'b1, 47, 1, 1'b1, 1'b1, 1, 23);
        step(1'b1, 47, 2, 1'b1, 1'b1, 1, 17);
        step(1'b1, 47, 3, 1'b1, 1'b1, 3, 5);
        drain();

        // Random backpressure
        acc = 0;
        for (int i = 0; i < 40000 && acc < 10000; i++)
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 0, 0);
        chk("acc10k", 32'(acc >= 10000), 1);
        drain();

        // Bubbles keep their position
        for (int k = 0; k < 12; k++) begin
            step(pat[k], 200 + k, k % 4, 1'b1, 1'b0, 0, 0);
            ov[k] = last_ov;
        end
        for (int k = 0; k < 12; k++) chk("bubble", 32'(ov[k]), (k >= 3) ? 32'(pat[k-3]) : 0);
        drain();

        // Asynchronous reset with samples in flight
        step(1'b1, 1000, 0, 1'b1, 1'b0, 0, 0);
        step(1'b1, 2000, 1, 1'b1, 1'b0, 0, 0);
        step(1'b1, 3000, 2, 1'b1, 1'b0, 0, 0);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        chk("pre_rst_ov", 32'(bus.o_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_ov", 32'(bus.o_valid), 0);
        chk("arst_out", {bus.o_quotient, bus.o_result}, 0);
        sb.delete();
        prev_stall = 1'b0;
        last_out   = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 25, 0, 1'b1, 1'b1, 2, 1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
            chk("post_rst_ov", 32'(last_ov), (k == 2) ? 1 : 0);
        end
        chk("post_rst_sb", sb.size(), 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
